adsr_env: RTL and testbench
===========================

// Module: adsr_env
// PURPOSE
//  ADSR envelope generator producing the 10-bit gain word for the Amp stage's amp input.
//  Gate-driven FSM steps a saturating envelope once per prescaled tick.
//  Sits directly upstream of Amp; Amp multiplies the oscillator sample by env.
// PARAMETERS
//  NBITS     10    envelope/rate/level width; MAX = 2**NBITS-1
//  PRESCALE  1000  clk cycles per envelope tick (100 kHz at 100 MHz); must be >= 2
// PORTS
//  clk           in   1      system clock
//  rst_n         in   1      reset, asynchronous assert, active-low
//  gate          in   1      note on (1) / off (0); synchronous to clk
//  attack_rate   in   NBITS  increment per tick in ATTACK; 0 = instant
//  decay_rate    in   NBITS  decrement per tick in DECAY; 0 = instant
//  sustain_lvl   in   NBITS  level held in SUSTAIN
//  release_rate  in   NBITS  decrement per tick in RELEASE; 0 = instant
//  env           out  NBITS  envelope level, registered
//  state         out  3      IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//  busy          out  1      1 when state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): env=0, state=IDLE, busy=0, tick counter=0, gate_q=0.
//  Tick: free-running counter 0..PRESCALE-1; tick=1 for one cycle when counter==PRESCALE-1.
//  Edge detect: gate_q <= gate; rise = gate & ~gate_q; fall = ~gate & gate_q.
//  Gate events act on any cycle; env steps only on tick; env/state update one clk after cause.
//  Priority per cycle: rise > fall > tick step. Edge and tick together: transition only, no step.
//  Transitions:
//   any state, rise          -> ATTACK (env kept, see CONFIGURATION)
//   ATTACK/DECAY/SUSTAIN, fall -> RELEASE (env kept)
//   RELEASE/IDLE, fall       -> no change
//   ATTACK tick:  env+rate computed in NBITS+1 bits; >= MAX or rate=0 -> env=MAX, DECAY
//   DECAY tick:   env-rate <= sustain_lvl (signed NBITS+1), or rate=0 -> env=sustain_lvl, SUSTAIN
//   SUSTAIN tick: env <= sustain_lvl (tracks live changes); stays while gate=1
//   RELEASE tick: env-rate <= 0 or rate=0 -> env=0, IDLE
//   IDLE: env held at 0
//  sustain_lvl >= env on entry to DECAY: first tick sets env=sustain_lvl (may rise), SUSTAIN.
//  Rates/levels sampled every tick; changes mid-phase apply on the next tick.
//  env never wraps: all add/sub saturate to [0, MAX].
//  Gate held high from reset: gate_q resets to 0, so the first cycle after release of rst_n
//   registers a rise -> ATTACK.
//  Reset mid-operation: immediate return to reset values; no partial step is kept.
// CONFIGURATION
//  ADSR_HARD_RETRIG_EN defined: on rise, env forced to 0 in the same update that enters ATTACK.
//  Not defined (default): soft retrigger; ATTACK resumes from current env (no click).
// TESTING (PRESCALE=4, NBITS=10)
//  1. gate=1, attack_rate=256 -> env 256,512,768,1023 on successive ticks; state 1->2 at 1023.
//  2. Continue, decay_rate=100, sustain_lvl=600 -> env 923,823,723,623,600; state=3.
//  3. gate=0 in SUSTAIN, release_rate=200 -> state=4 next clk; env 400,200,0; state=0, busy=0.
//  4. gate=0 during ATTACK at env=512 -> RELEASE from 512; release_rate=0 -> env=0, IDLE on next tick.
//  5. Rise during RELEASE at env=400 -> ATTACK from 400 (no macro) / from 0 (ADSR_HARD_RETRIG_EN).
//  6. rst_n=0 mid-DECAY (env=823) -> env=0, state=0 without clk edge; rise after deassert -> ATTACK.

Source files
------------

// File: rtl/adsr_env.sv
// adsr_env: gate-driven ADSR envelope that steps once every PRESCALE clk cycles.
// Define ADSR_HARD_RETRIG_EN to zero env on retrigger; default build retriggers softly.
module adsr_env #(
    parameter int NBITS    = 10,
    parameter int PRESCALE = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate,
    input  logic [NBITS-1:0] attack_rate,
    input  logic [NBITS-1:0] decay_rate,
    input  logic [NBITS-1:0] sustain_lvl,
    input  logic [NBITS-1:0] release_rate,
    output logic [NBITS-1:0] env,
    output logic [2:0]       state,
    output logic             busy
);
    localparam int               CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [NBITS-1:0] ENV_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t           st_q;
    state_t           st_nxt;
    logic [NBITS-1:0] env_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             gate_q;
    logic             tick;
    logic             rise;
    logic             fall;

    // Saturating add: result clamps to ENV_MAX, so "result == ENV_MAX" marks the peak.
    function automatic logic [NBITS-1:0] sat_add(input logic [NBITS-1:0] a,
                                                 input logic [NBITS-1:0] b);
        logic [NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, ENV_MAX}) ? ENV_MAX : s[NBITS-1:0];
    endfunction

    // Signed subtract clamped to a floor; landing exactly on the floor marks phase end.
    function automatic logic [NBITS-1:0] sat_sub(input logic [NBITS-1:0] a,
                                                 input logic [NBITS-1:0] b,
                                                 input logic [NBITS-1:0] fl);
        logic signed [NBITS:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d <= $signed({1'b0, fl})) ? fl : d[NBITS-1:0];
    endfunction

    assign tick  = (cnt_q == CNT_LAST);
    assign rise  = gate & ~gate_q;
    assign fall  = ~gate & gate_q;
    assign state = st_q;

    always_comb begin
        st_nxt  = st_q;
        env_nxt = env;
        if (rise) begin
            st_nxt = ATTACK;
`ifdef ADSR_HARD_RETRIG_EN
            env_nxt = '0;
`endif
        end else if (fall) begin
            if (st_q == ATTACK || st_q == DECAY || st_q == SUSTAIN)
                st_nxt = RELEASE;
        end else if (tick) begin
            case (st_q)
                ATTACK: begin
                    env_nxt = (attack_rate == '0) ? ENV_MAX : sat_add(env, attack_rate);
                    if (env_nxt == ENV_MAX)
                        st_nxt = DECAY;
                end
                DECAY: begin
                    env_nxt = (decay_rate == '0) ? sustain_lvl
                                                 : sat_sub(env, decay_rate, sustain_lvl);
                    if (env_nxt == sustain_lvl)
                        st_nxt = SUSTAIN;
                end
                SUSTAIN: env_nxt = sustain_lvl;
                RELEASE: begin
                    env_nxt = (release_rate == '0) ? '0 : sat_sub(env, release_rate, '0);
                    if (env_nxt == '0)
                        st_nxt = IDLE;
                end
                default: begin
                    st_nxt  = IDLE;
                    env_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= 1'b0;
            cnt_q  <= '0;
            st_q   <= IDLE;
            env    <= '0;
            busy   <= 1'b0;
        end else begin
            gate_q <= gate;
            cnt_q  <= tick ? '0 : cnt_q + 1'b1;
            st_q   <= st_nxt;
            env    <= env_nxt;
            busy   <= (st_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: directed ADSR scenarios plus randomized gate/rate traffic against a reference model.
`timescale 1ns/1ps
module tb_adsr_env;
    localparam int NB   = 10;
    localparam int PS   = 4;
    localparam int MAXV = (1 << NB) - 1;
`ifdef ADSR_HARD_RETRIG_EN
    localparam bit HARD = 1'b1;
`else
    localparam bit HARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          gate = 1'b0;
    logic [NB-1:0] attack_rate = '0;
    logic [NB-1:0] decay_rate = '0;
    logic [NB-1:0] sustain_lvl = '0;
    logic [NB-1:0] release_rate = '0;
    logic [NB-1:0] env;
    logic [2:0]    state;
    logic          busy;

    adsr_env #(.NBITS(NB), .PRESCALE(PS)) dut (
        .clk(clk), .rst_n(rst_n), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_lvl(sustain_lvl), .release_rate(release_rate),
        .env(env), .state(state), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    // Reference model: phase number, envelope level, tick phase and previous gate as integers.
    int m_env, m_st, m_cnt, m_gq;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_env = 0; m_st = 0; m_cnt = 0; m_gq = 0;
    endtask

    task automatic model_edge();
        bit rise, fall, tick;
        int a, d, s, r, e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        a = attack_rate; d = decay_rate; s = sustain_lvl; r = release_rate;
        rise = gate && !m_gq;
        fall = !gate && m_gq;
        tick = (m_cnt == PS - 1);
        m_cnt = (m_cnt + 1) % PS;
        m_gq  = gate;
        if (rise) begin
            m_st = 1;
            if (HARD) m_env = 0;
        end else if (fall) begin
            if (m_st >= 1 && m_st <= 3) m_st = 4;
        end else if (tick) begin
            case (m_st)
                1: begin e = m_env + a; if (a == 0 || e >= MAXV) begin m_env = MAXV; m_st = 2; end else m_env = e; end
                2: begin e = m_env - d; if (d == 0 || e <= s) begin m_env = s; m_st = 3; end else m_env = e; end
                3: m_env = s;
                4: begin e = m_env - r; if (r == 0 || e <= 0) begin m_env = 0; m_st = 0; end else m_env = e; end
                default: m_env = 0;
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("env", env, m_env);
        chk("state", state, m_st);
        chk("busy", busy, int'(m_st != 0));
    endtask

    task automatic wait_st(input string tag, input int target, input int lim);
        for (int i = 0; i < lim && state != target; i++) cyc();
        chk(tag, state, target);
    endtask

    task automatic wait_env(input string tag, input int target, input int lim);
        for (int i = 0; i < lim && env != target; i++) cyc();
        chk(tag, env, target);
    endtask

    function automatic logic [NB-1:0] rnd_rate();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return NB'($urandom_range(1, 16));
            default: return NB'($urandom_range(0, MAXV));
        endcase
    endfunction

    initial begin
        model_reset();
        #2;
        chk("rst_env", env, 0);
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Attack 256/tick to the peak, decay 100/tick down to sustain 600.
        attack_rate = 10'd256; decay_rate = 10'd100; sustain_lvl = 10'd600; release_rate = 10'd200;
        gate = 1'b1;
        cyc();
        chk("t1_attack", state, 1);
        wait_st("t1_decay", 2, 40);
        chk("t1_peak", env, 1023);
        wait_st("t2_sustain", 3, 60);
        chk("t2_sus_env", env, 600);

        // Release 200/tick from sustain.
        gate = 1'b0;
        cyc();
        chk("t3_release", state, 4);
        chk("t3_rel_env", env, 600);
        wait_st("t3_idle", 0, 40);
        chk("t3_env0", env, 0);
        chk("t3_busy0", busy, 0);

        // Gate drop mid-attack, instant release.
        attack_rate = 10'd256; release_rate = 10'd0;
        gate = 1'b1;
        cyc();
        wait_env("t4_512", 512, 40);
        gate = 1'b0;
        cyc();
        chk("t4_release", state, 4);
        chk("t4_rel_env", env, 512);
        wait_st("t4_idle", 0, 10);
        chk("t4_env0", env, 0);

        // Retrigger during release.
        attack_rate = 10'd400; release_rate = 10'd1;
        gate = 1'b1;
        cyc();
        wait_env("t5_400", 400, 20);
        gate = 1'b0;
        cyc();
        chk("t5_release", state, 4);
        gate = 1'b1;
        cyc();
        chk("t5_retrig", state, 1);
        chk("t5_retrig_env", env, HARD ? 0 : 400);

        // Asynchronous reset mid-decay, then gate still high re-enters attack.
        attack_rate = 10'd256; decay_rate = 10'd100; sustain_lvl = 10'd600;
        wait_env("t6_823", 823, 80);
        chk("t6_in_decay", state, 2);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("t6_rst_env", env, 0);
        chk("t6_rst_state", state, 0);
        chk("t6_rst_busy", busy, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_attack", state, 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            if ($urandom_range(0, 15) == 0) attack_rate = rnd_rate();
            if ($urandom_range(0, 15) == 0) decay_rate = rnd_rate();
            if ($urandom_range(0, 15) == 0) release_rate = rnd_rate();
            if ($urandom_range(0, 23) == 0) sustain_lvl = NB'($urandom_range(0, MAXV));
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("rnd_rst_env", env, 0);
                chk("rnd_rst_state", state, 0);
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
